// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
// EX-stage operand forwarding, ID-stage load-use / long-op hazard detection,
// a per-register pending scoreboard for out-of-order long-latency writebacks,
// and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   ex_rs                     ID/EX source regs, src i at [i*ADDR_W +: ADDR_W]
//   ex_mem_rd/_reg_write      EX/MEM destination and write enable
//   mem_wb_rd/_reg_write      MEM/WB destination and write enable
//   fwd_sel                   per-src ALU mux select: 00 reg, 01 WB, 10 MEM
//   id_rs, id_rs_used         IF/ID source regs and per-src read flags
//   id_rd, id_reg_write       IF/ID destination and write enable
//   id_is_long                IF/ID instruction is a long op
//   id_ex_rd, id_ex_mem_read  ID/EX destination and load flag
//   lo_issue(_rd)             long op leaves EX this cycle
//   lo_done(_rd)              long op writes back this cycle
//   stall, stall_cause        hazard stall and its cause (01 LU, 10 RAW, 11 WAW/struct)
//   pend_cnt, sb_full         in-flight long ops, scoreboard full
//   proto_err                 sticky issue/done protocol violation
//   stall_cycles              saturating count of stalled cycles
module fwd_hazard_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_rs,
    input  logic [ADDR_W-1:0]           ex_mem_rd,
    input  logic                        ex_mem_reg_write,
    input  logic [ADDR_W-1:0]           mem_wb_rd,
    input  logic                        mem_wb_reg_write,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic [ADDR_W-1:0]           id_rd,
    input  logic                        id_reg_write,
    input  logic                        id_is_long,
    input  logic [ADDR_W-1:0]           id_ex_rd,
    input  logic                        id_ex_mem_read,
    input  logic                        lo_issue,
    input  logic [ADDR_W-1:0]           lo_issue_rd,
    input  logic                        lo_done,
    input  logic [ADDR_W-1:0]           lo_done_rd,
    output logic                        stall,
    output logic [1:0]                  stall_cause,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
    output logic                        sb_full,
    output logic                        proto_err,
    output logic [CNT_W-1:0]            stall_cycles
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam int unsigned PCW  = $clog2(MAX_PEND + 1);

    logic [NREG-1:0]  pend_q, pend_d;
    logic [PCW-1:0]   pend_cnt_q, pend_cnt_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [NREG-1:0]  done_vec;
    logic [NREG-1:0]  issue_vec;
    logic [NREG-1:0]  eff_pend;
    logic             full;
    logic             done_hit;
    logic             issue_nz;
    logic             issue_room;
    logic             issue_dup;
    logic             issue_acc;
    logic             load_use;
    logic             raw_pend;
    logic             waw_struct;

    // EX forwarding select; MEM result is younger so it wins over WB.
    always_comb begin
        fwd_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if ((ex_rs[i*ADDR_W +: ADDR_W] != '0) && ex_mem_reg_write &&
                (ex_rs[i*ADDR_W +: ADDR_W] == ex_mem_rd)) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if ((ex_rs[i*ADDR_W +: ADDR_W] != '0) && mem_wb_reg_write &&
                         (ex_rs[i*ADDR_W +: ADDR_W] == mem_wb_rd)) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    // Scoreboard next state. A done frees its slot in the same cycle, so an
    // issue to a full scoreboard is accepted when a valid done accompanies it.
    always_comb begin
        full       = (pend_cnt_q == PCW'(MAX_PEND));
        done_hit   = lo_done && pend_q[lo_done_rd];
        done_vec   = '0;
        issue_vec  = '0;
        if (done_hit) begin
            done_vec[lo_done_rd] = 1'b1;
        end
        eff_pend   = pend_q & ~done_vec;
        issue_nz   = lo_issue && (lo_issue_rd != '0);
        issue_room = !full || done_hit;
        issue_dup  = eff_pend[lo_issue_rd];
        issue_acc  = issue_nz && issue_room && !issue_dup;
        if (issue_acc) begin
            issue_vec[lo_issue_rd] = 1'b1;
        end
        pend_d      = eff_pend | issue_vec;
        pend_cnt_d  = pend_cnt_q + PCW'(issue_acc) - PCW'(done_hit);
        proto_err_d = proto_err_q
                    || (issue_nz && !issue_room)
                    || (issue_nz && issue_dup)
                    || (lo_done && !pend_q[lo_done_rd]);
    end

    // ID hazard detection; eff_pend lets a consumer proceed in its producer's
    // writeback cycle because the register file writes in the first half.
    always_comb begin
        load_use   = 1'b0;
        raw_pend   = 1'b0;
        waw_struct = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*ADDR_W +: ADDR_W] != '0)) begin
                if (id_ex_mem_read && (id_rs[i*ADDR_W +: ADDR_W] == id_ex_rd)) begin
                    load_use = 1'b1;
                end
                if (eff_pend[id_rs[i*ADDR_W +: ADDR_W]]) begin
                    raw_pend = 1'b1;
                end
            end
        end
        if ((id_reg_write && eff_pend[id_rd]) || (id_is_long && full && !done_hit)) begin
            waw_struct = 1'b1;
        end
        if (load_use) begin
            stall_cause = 2'b01;
        end else if (raw_pend) begin
            stall_cause = 2'b10;
        end else if (waw_struct) begin
            stall_cause = 2'b11;
        end else begin
            stall_cause = 2'b00;
        end
        stall = (stall_cause != 2'b00);
    end

    // Saturating stall counter.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q         <= '0;
            pend_cnt_q     <= '0;
            proto_err_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            pend_q         <= pend_d;
            pend_cnt_q     <= pend_cnt_d;
            proto_err_q    <= proto_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pend_cnt     = pend_cnt_q;
    assign sb_full      = full;
    assign proto_err    = proto_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Testbench for fwd_hazard_scoreboard (MAX_PEND=4, CNT_W=4).
module tb_fwd_hazard_scoreboard;

    localparam int unsigned AW  = 5;
    localparam int unsigned NS  = 2;
    localparam int unsigned MP  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned PCW = $clog2(MP + 1);

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NS*AW-1:0]     ex_rs;
    logic [AW-1:0]        ex_mem_rd;
    logic                 ex_mem_reg_write;
    logic [AW-1:0]        mem_wb_rd;
    logic                 mem_wb_reg_write;
    logic [2*NS-1:0]      fwd_sel;
    logic [NS*AW-1:0]     id_rs;
    logic [NS-1:0]        id_rs_used;
    logic [AW-1:0]        id_rd;
    logic                 id_reg_write;
    logic                 id_is_long;
    logic [AW-1:0]        id_ex_rd;
    logic                 id_ex_mem_read;
    logic                 lo_issue;
    logic [AW-1:0]        lo_issue_rd;
    logic                 lo_done;
    logic [AW-1:0]        lo_done_rd;
    logic                 stall;
    logic [1:0]           stall_cause;
    logic [PCW-1:0]       pend_cnt;
    logic                 sb_full;
    logic                 proto_err;
    logic [CW-1:0]        stall_cycles;

    fwd_hazard_scoreboard #(
        .ADDR_W(AW), .NUM_SRC(NS), .MAX_PEND(MP), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_rs(ex_rs), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .fwd_sel(fwd_sel),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_long(id_is_long), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .lo_issue(lo_issue), .lo_issue_rd(lo_issue_rd), .lo_done(lo_done),
        .lo_done_rd(lo_done_rd), .stall(stall), .stall_cause(stall_cause),
        .pend_cnt(pend_cnt), .sb_full(sb_full), .proto_err(proto_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned ex_rs1, ex_rs0, exm_rd, exm_w, wb_rd, wb_w;
        int unsigned id_rs1, id_rs0, used, ixrd, mr;
        int unsigned e_fwd, e_stall, e_cause;
    } vec_t;

    typedef struct {
        string       nm;
        int unsigned e;
    } exp_t;

    vec_t        vecs[11];
    exp_t        expq[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned e);
        n_chk++;
        if (act == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, e);
    endtask

    task automatic push_exp(input string nm, input int unsigned e);
        exp_t x;
        x.nm = nm;
        x.e  = e;
        expq.push_back(x);
    endtask

    task automatic pop_chk(input int unsigned act);
        exp_t x;
        if (expq.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
            x = expq.pop_front();
            chk(x.nm, act, x.e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_rs = '0; ex_mem_rd = '0; ex_mem_reg_write = 1'b0;
        mem_wb_rd = '0; mem_wb_reg_write = 1'b0;
        id_rs = '0; id_rs_used = '0; id_rd = '0; id_reg_write = 1'b0;
        id_is_long = 1'b0; id_ex_rd = '0; id_ex_mem_read = 1'b0;
        lo_issue = 1'b0; lo_issue_rd = '0; lo_done = 1'b0; lo_done_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #3;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    // Issue one long op and check the registered count one edge later.
    task automatic issue(input int unsigned rd, input int unsigned exp_cnt, input string nm);
        lo_issue    = 1'b1;
        lo_issue_rd = AW'(rd);
        push_exp(nm, exp_cnt);
        step();
        lo_issue = 1'b0;
        pop_chk(32'(pend_cnt));
    endtask

    task automatic set_id_src0(input int unsigned rs);
        id_rs      = {AW'(0), AW'(rs)};
        id_rs_used = 2'b01;
        #1;
    endtask

    initial begin
        //            rs1 rs0 exm w  wb w  ir1 ir0 u ixrd mr  fwd st ca
        vecs[0]  = '{0,  5,  5,  1, 5, 1, 0,  0,  0, 0,  0,  2,  0, 0};
        vecs[1]  = '{0,  5,  5,  0, 5, 1, 0,  0,  0, 0,  0,  1,  0, 0};
        vecs[2]  = '{0,  0,  5,  1, 5, 1, 0,  0,  0, 0,  0,  0,  0, 0};
        vecs[3]  = '{3,  4,  3,  1, 4, 1, 0,  0,  0, 0,  0,  9,  0, 0};
        vecs[4]  = '{0,  6,  6,  0, 6, 0, 0,  0,  0, 0,  0,  0,  0, 0};
        vecs[5]  = '{6,  6,  6,  1, 9, 1, 0,  0,  0, 0,  0,  10, 0, 0};
        vecs[6]  = '{0,  0,  0,  0, 0, 0, 7,  2,  3, 7,  1,  0,  1, 1};
        vecs[7]  = '{0,  0,  0,  0, 0, 0, 7,  2,  1, 7,  1,  0,  0, 0};
        vecs[8]  = '{0,  0,  0,  0, 0, 0, 0,  0,  3, 0,  1,  0,  0, 0};
        vecs[9]  = '{0,  0,  0,  0, 0, 0, 7,  7,  3, 7,  0,  0,  0, 0};
        vecs[10] = '{0,  0,  0,  0, 0, 0, 2,  7,  1, 7,  1,  0,  1, 1};

        // Reset state
        idle();
        reset_n = 1'b0;
        #12;
        chk("rst_fwd",   32'(fwd_sel), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_cause", 32'(stall_cause), 0);
        chk("rst_pend",  32'(pend_cnt), 0);
        chk("rst_full",  32'(sb_full), 0);
        chk("rst_perr",  32'(proto_err), 0);
        chk("rst_cyc",   32'(stall_cycles), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Combinational forwarding / load-use table
        for (int i = 0; i < 11; i++) begin
            ex_rs            = {AW'(vecs[i].ex_rs1), AW'(vecs[i].ex_rs0)};
            ex_mem_rd        = AW'(vecs[i].exm_rd);
            ex_mem_reg_write = 1'(vecs[i].exm_w);
            mem_wb_rd        = AW'(vecs[i].wb_rd);
            mem_wb_reg_write = 1'(vecs[i].wb_w);
            id_rs            = {AW'(vecs[i].id_rs1), AW'(vecs[i].id_rs0)};
            id_rs_used       = 2'(vecs[i].used);
            id_ex_rd         = AW'(vecs[i].ixrd);
            id_ex_mem_read   = 1'(vecs[i].mr);
            push_exp($sformatf("vec%0d_fwd", i), vecs[i].e_fwd);
            push_exp($sformatf("vec%0d_stall", i), vecs[i].e_stall);
            push_exp($sformatf("vec%0d_cause", i), vecs[i].e_cause);
            #1;
            pop_chk(32'(fwd_sel));
            pop_chk(32'(stall));
            pop_chk(32'(stall_cause));
            step();
        end

        // Long-op RAW with same-cycle done bypass
        do_reset();
        issue(9, 1, "raw_pend1");
        set_id_src0(9);
        chk("raw_stall", 32'(stall), 1);
        chk("raw_cause", 32'(stall_cause), 2);
        chk("raw_cyc0",  32'(stall_cycles), 0);
        step();
        chk("raw_cyc1",  32'(stall_cycles), 1);
        step();
        chk("raw_cyc2",  32'(stall_cycles), 2);
        lo_done = 1'b1; lo_done_rd = AW'(9);
        #1;
        chk("raw_bypass_stall", 32'(stall), 0);
        chk("raw_bypass_cause", 32'(stall_cause), 0);
        step();
        lo_done = 1'b0;
        #1;
        chk("raw_done_pend", 32'(pend_cnt), 0);
        chk("raw_done_cyc",  32'(stall_cycles), 2);
        chk("raw_done_perr", 32'(proto_err), 0);
        chk("raw_done_stall", 32'(stall), 0);

        // Full scoreboard / structural hazard
        do_reset();
        for (int r = 1; r <= 4; r++) issue(r, r, $sformatf("full_issue%0d", r));
        chk("full_flag", 32'(sb_full), 1);
        chk("full_perr0", 32'(proto_err), 0);
        id_is_long = 1'b1;
        #1;
        chk("struct_stall", 32'(stall), 1);
        chk("struct_cause", 32'(stall_cause), 3);
        lo_done = 1'b1; lo_done_rd = AW'(2);
        #1;
        chk("struct_relief", 32'(stall), 0);
        lo_done = 1'b0; id_is_long = 1'b0;
        id_reg_write = 1'b1; id_rd = AW'(3);
        #1;
        chk("waw_cause", 32'(stall_cause), 3);
        id_reg_write = 1'b0; id_rd = '0;
        issue(5, 4, "overflow_pend");
        chk("overflow_perr", 32'(proto_err), 1);
        chk("overflow_full", 32'(sb_full), 1);
        lo_issue = 1'b1; lo_issue_rd = AW'(10);
        lo_done  = 1'b1; lo_done_rd  = AW'(1);
        step();
        idle();
        #1;
        chk("swap_pend", 32'(pend_cnt), 4);
        set_id_src0(10);
        chk("swap_bit10_cause", 32'(stall_cause), 2);
        set_id_src0(1);
        chk("swap_bit1_clear", 32'(stall), 0);
        set_id_src0(5);
        chk("dropped_bit5_clear", 32'(stall), 0);
        idle();

        // Protocol errors and asynchronous reset
        do_reset();
        issue(0, 0, "x0_issue_pend");
        chk("x0_issue_perr", 32'(proto_err), 0);
        issue(9, 1, "p_issue9");
        lo_issue = 1'b1; lo_issue_rd = AW'(9);
        lo_done  = 1'b1; lo_done_rd  = AW'(9);
        step();
        idle();
        #1;
        chk("same_rd_pend", 32'(pend_cnt), 1);
        chk("same_rd_perr", 32'(proto_err), 0);
        issue(9, 1, "dup_pend");
        chk("dup_perr", 32'(proto_err), 1);
        do_reset();
        issue(9, 1, "p2_issue9");
        lo_done = 1'b1; lo_done_rd = AW'(12);
        step();
        lo_done = 1'b0;
        #1;
        chk("bad_done_perr", 32'(proto_err), 1);
        chk("bad_done_pend", 32'(pend_cnt), 1);
        set_id_src0(9);
        step();
        step();
        chk("pre_rst_cyc", 32'(stall_cycles), 2);
        chk("pre_rst_stall", 32'(stall), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pend",  32'(pend_cnt), 0);
        chk("arst_perr",  32'(proto_err), 0);
        chk("arst_stall", 32'(stall), 0);
        chk("arst_cyc",   32'(stall_cycles), 0);
        chk("arst_full",  32'(sb_full), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        idle();

        // Stall counter saturation
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_rd = AW'(7);
        set_id_src0(7);
        repeat (14) step();
        chk("sat_cyc14", 32'(stall_cycles), 14);
        repeat (6) step();
        chk("sat_cyc20", 32'(stall_cycles), 15);
        idle();

        chk("sb_drained", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
